// File: rtl/xor_chk_pkg.sv
// Shared types and constants for the XOR frame checksum block.
package xor_chk_pkg;

  localparam int FRM_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/xor_frame_chk.sv
// XOR-folds FRAME_LEN words per frame and delivers the checksum over a valid/ready output.
// Optional compare against exp_sum is enabled by defining XOR_FRAME_CHK_CMP_EN.
module xor_frame_chk
  import xor_chk_pkg::*;
#(
  parameter int N         = 4,
  parameter int FRAME_LEN = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_vld,
  input  logic [N-1:0]         in_data,
  output logic                 in_rdy,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [N-1:0]         out_sum,
  output logic [FRM_CNT_W-1:0] frm_cnt
`ifdef XOR_FRAME_CHK_CMP_EN
  ,
  input  logic [N-1:0]         exp_sum,
  output logic                 mis,
  output logic                 err_sticky
`endif
);

  // Handshakes: a word transfers when in_vld && in_rdy; the checksum
  // transfers when out_vld && out_rdy. Flush overrides both.
  localparam int WCNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [WCNT_W-1:0] LAST = WCNT_W'(FRAME_LEN - 1);

  state_t            state, state_nxt;
  logic [N-1:0]      acc;
  logic [WCNT_W-1:0] wcnt;
  logic              beat, last_beat, out_hs;

  assign in_rdy    = (state != DONE);
  assign beat      = in_vld && in_rdy;
  assign last_beat = beat && (wcnt == LAST);
  assign out_hs    = out_vld && out_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (beat) state_nxt = last_beat ? DONE : ACC;
      ACC:     if (last_beat) state_nxt = DONE;
      DONE:    if (out_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

`ifdef XOR_FRAME_CHK_CMP_EN
  assign mis = out_vld && (out_sum != exp_sum);
`endif

  // Beats and the output handshake are exclusive: in_rdy is low exactly while out_vld is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      wcnt       <= '0;
      out_sum    <= '0;
      out_vld    <= 1'b0;
      frm_cnt    <= '0;
`ifdef XOR_FRAME_CHK_CMP_EN
      err_sticky <= 1'b0;
`endif
    end else if (flush) begin
      acc        <= '0;
      wcnt       <= '0;
      out_vld    <= 1'b0;
`ifdef XOR_FRAME_CHK_CMP_EN
      err_sticky <= 1'b0;
`endif
    end else begin
      if (beat) begin
        acc  <= acc ^ in_data;
        wcnt <= wcnt + WCNT_W'(1);
      end
      if (last_beat) begin
        out_sum <= acc ^ in_data;
        out_vld <= 1'b1;
      end
      if (out_hs) begin
        acc     <= '0;
        wcnt    <= '0;
        out_vld <= 1'b0;
        frm_cnt <= frm_cnt + FRM_CNT_W'(1);
`ifdef XOR_FRAME_CHK_CMP_EN
        if (mis) err_sticky <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_xor_frame_chk.sv
// Directed bench for xor_frame_chk (N=4, FRAME_LEN=4); compare checks need XOR_FRAME_CHK_CMP_EN.
module tb_xor_frame_chk;

  logic       clk = 1'b0;
  logic       rst, flush, in_vld, out_rdy;
  logic [3:0] in_data;
  logic       in_rdy, out_vld;
  logic [3:0] out_sum;
  logic [7:0] frm_cnt;
`ifdef XOR_FRAME_CHK_CMP_EN
  logic [3:0] exp_sum;
  logic       mis, err_sticky;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  xor_frame_chk #(.N(4), .FRAME_LEN(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_vld(in_vld), .in_data(in_data),
    .in_rdy(in_rdy), .out_vld(out_vld), .out_rdy(out_rdy), .out_sum(out_sum),
    .frm_cnt(frm_cnt)
`ifdef XOR_FRAME_CHK_CMP_EN
    , .exp_sum(exp_sum), .mis(mis), .err_sticky(err_sticky)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [3:0] d);
    in_vld  = 1'b1;
    in_data = d;
    tick();
    in_vld  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_vld = 1'b1; in_data = 4'hF; out_rdy = 1'b0;
`ifdef XOR_FRAME_CHK_CMP_EN
    exp_sum = 4'h0;
`endif
    // reset with in_vld held high
    repeat (3) tick();
    check("rst_out_vld", out_vld, 0);
    check("rst_frm_cnt", frm_cnt, 0);
    check("rst_in_rdy", in_rdy, 1);
    check("rst_out_sum", out_sum, 0);
    rst = 1'b0; in_vld = 1'b0;
    tick();

    // back-to-back frame
    out_rdy = 1'b1;
    beat(4'h1); beat(4'h2); beat(4'h4);
    check("b2b_vld_early", out_vld, 0);
    beat(4'h8);
    check("b2b_vld", out_vld, 1);
    check("b2b_sum", out_sum, 4'hF);
    check("b2b_in_rdy_done", in_rdy, 0);
    tick();
    check("b2b_vld_drop", out_vld, 0);
    check("b2b_frm_cnt", frm_cnt, 1);
    check("b2b_in_rdy_idle", in_rdy, 1);

    // backpressure with words offered in DONE
    out_rdy = 1'b0;
    beat(4'h3); beat(4'h5); beat(4'h6); beat(4'h9);
    in_vld = 1'b1; in_data = 4'hF;
    for (int i = 0; i < 5; i++) begin
      check("bp_vld", out_vld, 1);
      check("bp_sum", out_sum, 4'h9);
      check("bp_in_rdy", in_rdy, 0);
      tick();
    end
    in_vld = 1'b0; out_rdy = 1'b1;
    tick();
    check("bp_hs_vld", out_vld, 0);
    check("bp_hs_frm", frm_cnt, 2);
    beat(4'h1); beat(4'h1); beat(4'h2); beat(4'h0);
    check("bp_next_sum", out_sum, 4'h2);
    check("bp_next_vld", out_vld, 1);
    tick();
    check("bp_next_frm", frm_cnt, 3);

    // gaps between beats
    beat(4'hA); tick();
    check("gap_in_rdy", in_rdy, 1);
    check("gap_vld", out_vld, 0);
    beat(4'hA); beat(4'h3); tick(); tick();
    check("gap_vld2", out_vld, 0);
    beat(4'h3);
    check("gap_vld3", out_vld, 1);
    check("gap_sum", out_sum, 4'h0);
    tick();
    check("gap_frm", frm_cnt, 4);

    // flush after two beats, with a simultaneous beat
    beat(4'h7); beat(4'hC);
    flush = 1'b1; in_vld = 1'b1; in_data = 4'hF;
    tick();
    flush = 1'b0; in_vld = 1'b0;
    check("fl_vld", out_vld, 0);
    check("fl_frm_keep", frm_cnt, 4);
    beat(4'h5); beat(4'h0); beat(4'h0); beat(4'h0);
    check("fl_sum", out_sum, 4'h5);
    check("fl_sum_vld", out_vld, 1);
    tick();
    check("fl_frm", frm_cnt, 5);

    // flush in DONE beats a simultaneous output handshake
    beat(4'h1); beat(4'h2); beat(4'h3); beat(4'h4);
    check("fld_sum", out_sum, 4'h4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fld_vld", out_vld, 0);
    check("fld_frm", frm_cnt, 5);
    check("fld_in_rdy", in_rdy, 1);

    // async reset in DONE, observed between clock edges
    out_rdy = 1'b0;
    beat(4'h1); beat(4'h0); beat(4'h0); beat(4'h0);
    check("ar_vld_pre", out_vld, 1);
    rst = 1'b1;
    #2;
    check("ar_vld", out_vld, 0);
    check("ar_frm", frm_cnt, 0);
    check("ar_in_rdy", in_rdy, 1);
    check("ar_sum", out_sum, 0);
    tick();
    rst = 1'b0;
    tick();

`ifdef XOR_FRAME_CHK_CMP_EN
    exp_sum = 4'hE; out_rdy = 1'b0;
    beat(4'h1); beat(4'h2); beat(4'h4); beat(4'h8);
    check("cmp_mis", mis, 1);
    check("cmp_err_pre", err_sticky, 0);
    out_rdy = 1'b1;
    tick();
    check("cmp_err", err_sticky, 1);
    exp_sum = 4'hF;
    beat(4'h1); beat(4'h2); beat(4'h4); beat(4'h8);
    check("cmp_mis_ok", mis, 0);
    tick();
    check("cmp_err_hold", err_sticky, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("cmp_err_clr", err_sticky, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/xor_frame_chk.md
XOR_FRAME_CHK -- requirements
Module: xor_frame_chk

Interface
REQ-001 SHALL have parameter N, default 4: data word width in bits.
REQ-002 SHALL have parameter FRAME_LEN, default 8: words per frame; legal range 1..256.
REQ-003 SHALL use one clock, clk; reset is rst, asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 flush  input  1  synchronous frame abort.
REQ-007 in_vld  input  1  in_data is valid this cycle.
REQ-008 in_data  input  N  registered XOR result word from the upstream XOR stage.
REQ-009 in_rdy  output  1  block can accept a word this cycle.
REQ-010 out_vld  output  1  out_sum holds a completed frame checksum.
REQ-011 out_rdy  input  1  consumer accepts out_sum.
REQ-012 out_sum  output  N  XOR-fold of all words in the frame.
REQ-013 frm_cnt  output  8  count of frames delivered, modulo 256.

Function
REQ-014 SHALL implement the states IDLE (no words held), ACC (1..FRAME_LEN-1 words held) and DONE (checksum pending).
REQ-015 SHALL define a beat as in_vld && in_rdy.
- On each beat: acc <= acc ^ in_data and wcnt <= wcnt + 1.
REQ-016 SHALL make in_rdy a function of state only: 1 in IDLE and ACC, 0 in DONE.
REQ-017 SHALL move IDLE->ACC on the first beat, or IDLE->DONE on that beat when FRAME_LEN == 1.
REQ-018 SHALL move ACC->DONE on the beat where wcnt == FRAME_LEN-1.
- On that edge, out_sum is loaded with acc ^ in_data.
- out_vld rises the cycle after the last beat (latency 1).
REQ-019 SHALL hold out_vld = 1 and out_sum stable in DONE until out_vld && out_rdy.
- On that handshake: go to IDLE, clear acc and wcnt, frm_cnt <= frm_cnt + 1 (wraps 255->0).
REQ-020 SHALL ignore in_vld in DONE: no word is accepted and none is lost.
REQ-021 SHALL, when flush = 1 in any state, go to IDLE next cycle.
- Clears acc, wcnt and out_vld.
- Leaves frm_cnt unchanged.
- Has priority over a simultaneous beat or output handshake; neither takes effect.
REQ-022 SHALL tolerate idle cycles between beats: the state holds and acc is unchanged when in_vld = 0.
REQ-023 SHALL size wcnt as max(1, $clog2(FRAME_LEN)) bits; all XOR arithmetic is N bits wide with no carries.

Reset
REQ-024 SHALL, while rst = 1, immediately force state = IDLE, acc = 0, wcnt = 0, out_sum = 0, out_vld = 0 and frm_cnt = 0.
- in_rdy therefore reads 1 after reset.
REQ-025 SHALL, when rst asserts mid-frame or in DONE, discard the partial or pending frame with no output handshake.

Configuration
REQ-026 SHALL, when macro XOR_FRAME_CHK_CMP_EN is defined, add the following:
- Input exp_sum [N-1:0].
- Output mis = out_vld && (out_sum != exp_sum).
- Output err_sticky: set on an output handshake with mis = 1; cleared only by rst or flush.
REQ-027 SHALL, when XOR_FRAME_CHK_CMP_EN is undefined, omit exp_sum, mis and err_sticky and leave all other behaviour identical.

Structure
REQ-028 SHALL place the following in the shared package xor_chk_pkg:
- The state typedef with IDLE/ACC/DONE encodings.
- Constant FRM_CNT_W = 8.
REQ-029 SHALL be a single module with no sub-module.
REQ-030 SHALL register all outputs except in_rdy and mis.

Verification (N=4, FRAME_LEN=4)
REQ-031 Reset: rst pulse with in_vld = 1 -> out_vld = 0, frm_cnt = 0, in_rdy = 1, no beat counted during reset.
REQ-032 Back-to-back: beats 4'h1, 4'h2, 4'h4, 4'h8 with out_rdy = 1 -> out_vld = 1 for one cycle, starting the cycle after the 4th beat, out_sum = 4'hF, then frm_cnt = 1.
REQ-033 Backpressure: out_rdy = 0 for 5 cycles with in_vld = 1 -> out_sum held, in_rdy = 0, no beats taken; out_rdy = 1 -> handshake, IDLE; the next frame is unaffected by the held words.
REQ-034 Gaps: 4'hA, idle, 4'hA, 4'h3, idle, idle, 4'h3 -> out_sum = 4'h0.
REQ-035 Flush and async reset:
- Flush after 2 beats, then 4'h5, 0, 0, 0 -> out_sum = 4'h5, frm_cnt increments once.
- rst asserted in DONE -> out_vld drops without a clock edge.
REQ-036 CMP_EN build: frame summing to 4'hF with exp_sum = 4'hE -> mis = 1 and err_sticky = 1 after handshake; err_sticky stays 1 through a matching frame and clears on flush.
